// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Target end of the CPU data port. It accepts load/store requests and runs
//   them on an internal word-organised RAM with big-endian byte lanes. After
//   WAIT_STATES extra cycles it returns a one-cycle ack. Store data arrives
//   right-aligned. Load data goes back raw, right-aligned and zero-filled.
//
//   Optional feature macro: DMEM_ERR_EN
//     defined   : reserved-size, misalignment and out-of-range requests are
//                 answered at once with err=1, and the RAM is not written.
//     undefined : err is tied low. Low address bits are masked to the access
//                 size, size=11 acts as a word access, and the word index
//                 wraps modulo DEPTH_WORDS.
//
//   Parameters
//     DEPTH_WORDS : RAM depth in 32-bit words (power of two, >= 4)
//     WAIT_STATES : extra cycles between request acceptance and ack (0-15)
//
//   Ports
//     clk    in   system clock, rising edge
//     reset  in   asynchronous active-low reset
//     req    in   request valid, held until ack
//     wr     in   1 = store, 0 = load
//     size   in   00 byte, 01 half, 10 word, 11 reserved
//     addr   in   byte address
//     wdata  in   right-aligned store data
//     ack    out  one-cycle completion pulse
//     rdata  out  right-aligned load data, zero outside the ack cycle
//     err    out  bad-request flag, only together with ack
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for req; captures the request when it is seen
//   WAIT  | counting down wait states on the captured request
//   RESP  | ack cycle; req is ignored and the FSM returns to IDLE
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        capture;
  logic        enter_resp;

  logic        cap_wr;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic        in_bad;
  logic        op_bad;
  logic        op_wr;
  logic [1:0]  op_size;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [1:0]  op_off;
  logic [AW-1:0] word_idx;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_word;
  logic [31:0] lane_mask;
  logic [4:0]  shift;
  logic [31:0] wr_word;
  logic [31:0] rd_word;
  logic        mem_we;

  // Only the index bits of the address reach the RAM.
  logic        unused_addr;
  assign unused_addr = ^op_addr;

`ifdef DMEM_ERR_EN
  always_comb begin
    in_bad = 1'b0;
    case (size)
      2'b11:   in_bad = 1'b1;
      2'b01:   in_bad = addr[0];
      2'b10:   in_bad = (addr[1:0] != 2'b00);
      default: in_bad = 1'b0;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) in_bad = 1'b1;
  end
`else
  assign in_bad = 1'b0;
`endif

  // Entering RESP straight from IDLE (bad request or zero wait states) has
  // to act on the live inputs, because the captured copy is still being
  // loaded on that same edge.
  always_comb begin
    if (state == IDLE) begin
      op_wr    = wr;
      op_size  = size;
      op_addr  = addr;
      op_wdata = wdata;
    end else begin
      op_wr    = cap_wr;
      op_size  = cap_size;
      op_addr  = cap_addr;
      op_wdata = cap_wdata;
    end
  end

  assign op_bad   = (state == IDLE) && in_bad;
  assign op_off   = op_addr[1:0];
  assign word_idx = op_addr[AW+1:2];
  assign mem_word = mem[word_idx];

  // Big-endian lanes: byte offset 0 sits in [31:24], so the right shift is
  // (3 - off) * 8, which is just the inverted offset times 8. Halves drop
  // addr[0], and size=11 falls through to the word case.
  always_comb begin
    shift     = 5'd0;
    lane_mask = 32'hFFFF_FFFF;
    case (op_size)
      2'b00: begin
        shift     = {~op_off, 3'b000};
        lane_mask = 32'h0000_00FF << shift;
      end
      2'b01: begin
        shift     = {~op_off[1], 4'b0000};
        lane_mask = 32'h0000_FFFF << shift;
      end
      default: begin
        shift     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign wr_word = (mem_word & ~lane_mask) | ((op_wdata << shift) & lane_mask);
  assign rd_word = (mem_word & lane_mask) >> shift;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (in_bad || (WAIT_STATES == 0)) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_wr    <= 1'b0;
      cap_size  <= 2'b00;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        cap_wr    <= wr;
        cap_size  <= size;
        cap_addr  <= addr;
        cap_wdata <= wdata;
      end
      ack   <= enter_resp;
      err   <= enter_resp && op_bad;
      rdata <= (enter_resp && !op_bad && !op_wr) ? rd_word : 32'd0;
    end
  end

  // The RAM has no reset. The write is gated by reset so that a store that
  // was in flight when reset asserted is dropped.
  assign mem_we = enter_resp && !op_bad && op_wr && reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= wr_word;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the single-cycle CPU's data port: it accepts load/store requests from the CPU, performs them on an internal word-organised RAM with big-endian byte lanes, and returns a one-cycle acknowledge after a fixed number of wait states. It is the target end of the CPU's memory access path. The CPU drives right-aligned store data that has already been size-filtered. The CPU applies load sign/zero extension in write-back, so this block returns raw, right-aligned, zero-filled read data.

## Interface
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two, ≥ 4.
- WAIT_STATES, 1, extra cycles between request acceptance and ack; 0–15.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request valid; held by the requester until ack.
- wr  in  1  1 = store, 0 = load; stable while req is high.
- size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- addr  in  32  byte address; stable while req is high.
- wdata  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- ack  out  1  one-cycle completion pulse.
- rdata  out  32  load data, right-aligned and zero-filled; valid only while ack=1, 0 otherwise.
- err  out  1  error flag; high only together with ack.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE with req=1:
  - Capture wr, size, addr and wdata.
  - Bad request → RESP with error.
  - Good request and WAIT_STATES=0 → RESP.
  - Good request otherwise → WAIT, with wait counter loaded to WAIT_STATES-1.
- IDLE with req=0 → stay in IDLE.
- WAIT: decrement the counter; when it is 0, go to RESP.
- RESP: ack=1 for exactly one cycle, then unconditionally return to IDLE. req is ignored in the RESP cycle.
- Bad request, any one of:
  - size=11.
  - size=01 with addr[0]=1.
  - size=10 with addr[1:0]≠00.
  - addr[31:2] ≥ DEPTH_WORDS.
- Bad-request response: no wait states, no RAM write, rdata=0, err=1 with ack.
- Byte lanes are big-endian:
  - Byte at offset 0 is word bits [31:24], offset 3 is [7:0].
  - Half at offset 0 is [31:16], offset 2 is [15:0].
- Store: only the addressed lanes are written, from wdata[7:0] (byte) or wdata[15:0] (half). The other lanes are unchanged.
- Load: the addressed lane(s) are shifted to rdata LSBs; upper bits are 0.
- RAM contents are not cleared by reset; their power-up value is undefined.

## Timing
- Reset (asynchronous, while reset=0): state=IDLE, counter=0, ack=0, err=0, rdata=0, captured request cleared.
- ack, err and rdata are registered outputs.
- Latency: req sampled high at edge N → ack high during the cycle after edge N+WAIT_STATES.
- Bad request: ack after edge N.
- Store commit: the RAM write occurs at the edge that enters RESP.
- Load data: read from RAM at that same edge and registered into rdata.
- Throughput: at most one transaction per WAIT_STATES+2 cycles. The next req is sampled no earlier than the edge that leaves RESP.
- Requester drops req in the ack cycle. A req still high at the edge leaving RESP is not sampled; it is sampled in IDLE on the following edge as a new request.
- Reset asserted mid-transaction: the transaction is abandoned, no ack is produced, and a pending store is not committed.
- Inputs changing during WAIT have no effect; the captured copies are used.

## Configuration
- DMEM_ERR_EN defined:
  - Alignment, reserved-size and range checks are active as described.
  - err behaves as specified.
- DMEM_ERR_EN undefined:
  - err is tied to 0 and no request is classified bad.
  - addr[1:0] is masked for words, addr[0] for halves.
  - size=11 is treated as word.
  - Word index wraps modulo DEPTH_WORDS.
  - All requests take the normal wait-state path.

## Test plan
- Reset with reset=0 mid-WAIT, then release → ack=0, err=0, rdata=0, FSM in IDLE. The following store to 0x10 is not affected by the abandoned request.
- WAIT_STATES=1. Word store 0xDEADBEEF to 0x20, then word load from 0x20:
  - ack pulses 2 cycles after each req sample.
  - Load rdata=0xDEADBEEF.
- Byte store 0x5A to 0x21 over 0xDEADBEEF, then byte load 0x21 → rdata=0x0000005A; word load 0x20 → 0xDE5ABEEF.
- Half store 0x1234 to 0x22, then half load 0x22 → rdata=0x00001234; word load 0x20 → 0xDE5A1234.
- With DMEM_ERR_EN:
  - Word load at 0x23 → ack=1, err=1, rdata=0 one cycle after req, no wait states.
  - Store to word index DEPTH_WORDS → err=1 and RAM unchanged.
  - Without the macro, word load at 0x23 returns the word at 0x20.
- Back-to-back requests with req held high through ack → exactly WAIT_STATES+2 cycles between ack pulses; no duplicated or dropped transaction.
